l2_mem_responder: RTL and testbench
===================================

# l2_mem_responder

Memory-side responder for the L2's off-chip request channel. Accepts LOAD_MEM and STORE_MEM packets that the L2 emits on its NoC2 output, serves them from a small line-organised backing store, and returns LOAD_MEM_ACK and STORE_MEM_ACK packets on NoC3. It is the far end of the L2 memory interface and is used both as the L2 bench memory and as the stimulus source for the L2's ACK-handling instructions.

## Interface
- IDX_W, 4: line-index width; the store holds 2^IDX_W lines.
- LINE_FLITS, 8: 64-bit data flits per line.
- RESP_DELAY, 2: idle cycles between the last request flit and the first response flit (0 allowed).
- ADDR_LO, 6: LSB of the line index within the 40-bit address.
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- noc2_valid_in  in  1  request flit valid.
- noc2_data_in  in  64  request flit.
- noc2_ready_in  out  1  responder can accept a request flit.
- noc3_valid_out  out  1  response flit valid.
- noc3_data_out  out  64  response flit.
- noc3_ready_out  in  1  downstream accepts the response flit.
- busy  out  1  a packet is in progress (any state other than RX_HDR).
- err_type  out  1  sticky; set on an unsupported message type.

## Operation
- Header flit fields: [63:50] chipid, [49:42] x, [41:34] y, [33:30] fbits, [29:22] payload_len, [21:14] msg_type, [13:6] mshrid, [5:0] options.
- Message types: LOAD_MEM = 8'd19, STORE_MEM = 8'd20, LOAD_MEM_ACK = 8'd24, STORE_MEM_ACK = 8'd25.
- Request framing: the header is followed by exactly payload_len flits. Flit 1 carries the address in [39:0]; line index = addr[ADDR_LO +: IDX_W]. Flit 2 carries the return chipid/x/y in the header bit positions. Flits 3.. are data beats 0, 1, ….
- FSM: RX_HDR -> RX_ADDR -> RX_SRC -> RX_DATA (only if payload_len > 2) -> WAIT -> TX_HDR -> TX_DATA (only for LOAD) -> RX_HDR.
  - payload_len of 0 or 1: go straight to WAIT after the last flit; address and source are taken as 0.
  - Unsupported type: all payload_len flits are consumed, err_type is set, and the FSM returns to RX_HDR with no response.
- STORE_MEM: each data beat k < LINE_FLITS is written to mem[idx][k] on its handshake. Beats k >= LINE_FLITS are dropped. A short packet leaves the remaining beats unchanged. The ack is always sent.
- LOAD_MEM: any data flits are consumed and ignored.
- Response header:
  - chipid/x/y = the captured return fields; fbits = 0; options = 0; mshrid = the request mshrid.
  - msg_type = the corresponding ACK type.
  - payload_len = LINE_FLITS for LOAD_MEM_ACK, 0 for STORE_MEM_ACK.
- LOAD_MEM_ACK data beat k = mem[idx][k]. The store is read combinationally, so a load that follows a store sees the stored data.
- Store contents are not reset and are undefined until written.
- Reset values: noc2_ready_in 0, noc3_valid_out 0, noc3_data_out 0, busy 0, err_type 0; FSM in RX_HDR.

## Timing
- noc2_ready_in = 1 exactly in RX_HDR/RX_ADDR/RX_SRC/RX_DATA. It rises on the first clk edge after rst_n deasserts.
- A flit transfers on a cycle with valid && ready. Only one packet is in flight; no new header is accepted until the response has fully drained.
- If the last request flit is accepted in cycle T, noc3_valid_out first asserts in cycle T+1+RESP_DELAY.
- noc3_valid_out and noc3_data_out are registered. They are held stable while noc3_ready_out is low. The next flit is presented in the cycle after a handshake.
- Back-to-back response flits are sent at 1 flit/cycle when noc3_ready_out is held high.
- If the last response flit is accepted in cycle U, noc2_ready_in is 1 in cycle U+1.
- Unsupported packet: noc2_ready_in stays high continuously. err_type rises the cycle after the header handshake.
- rst_n asserted mid-packet: immediate abort; the response is discarded; beats already written remain in the store.

## Test plan
- STORE_MEM, addr 0x40 (idx 1), mshrid 5, 8 beats 0x11..0x88, RESP_DELAY 2 -> one flit with msg_type 25, payload_len 0, mshrid 5, valid 3 cycles after the last beat.
- LOAD_MEM to addr 0x40 after that store -> header with msg_type 24, payload_len 8, then beats 0x11..0x88 in order, return chipid/x/y echoed.
- Load response with noc3_ready_out low for 4 cycles on beat 3 -> beat 3 data held constant, no beat lost or duplicated, noc2_ready_in stays 0 until the final beat is accepted.
- Header with msg_type 8'd7, payload_len 4 -> 4 flits consumed at full rate, err_type = 1, no noc3_valid_out.
- STORE_MEM with payload_len 12 (10 beats) -> beats 0-7 written, 8-9 dropped, ack sent. A following load returns only beats 0-7.
- rst_n pulsed low during RX_DATA of a store -> all outputs reset immediately; after release, noc2_ready_in = 1 and a fresh LOAD_MEM completes normally.

Source files
------------

// File: rtl/l2_mem_responder.sv
// Memory-side responder for the L2 off-chip channel: serves LOAD_MEM / STORE_MEM
// request packets from a line-organised store and returns the matching ACK packets.
module l2_mem_responder #(
    parameter int IDX_W      = 4,
    parameter int LINE_FLITS = 8,
    parameter int RESP_DELAY = 2,
    parameter int ADDR_LO    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        noc2_valid_in,
    input  logic [63:0] noc2_data_in,
    output logic        noc2_ready_in,
    output logic        noc3_valid_out,
    output logic [63:0] noc3_data_out,
    input  logic        noc3_ready_out,
    output logic        busy,
    output logic        err_type
);
    localparam logic [7:0] LOAD_MEM      = 8'd19;
    localparam logic [7:0] STORE_MEM     = 8'd20;
    localparam logic [7:0] LOAD_MEM_ACK  = 8'd24;
    localparam logic [7:0] STORE_MEM_ACK = 8'd25;
    localparam int BEAT_W = (LINE_FLITS > 1) ? $clog2(LINE_FLITS) : 1;
    localparam int DLY_W  = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [7:0]        LINE_LEN  = 8'(LINE_FLITS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_FLITS - 1);

    typedef enum logic [2:0] {
        RX_HDR, RX_ADDR, RX_SRC, RX_DATA, WAIT, TX_HDR, TX_DATA
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic               bad_q, bad_d;
    logic [7:0]         mshr_q, mshr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [29:0]        src_q, src_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [7:0]         rx_beat_q, rx_beat_d;
    logic [BEAT_W-1:0]  tx_beat_q, tx_beat_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [63:0]        data_q, data_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               rx_fire, tx_fire, req_done, start_tx, wr_en;
    logic [7:0]         in_type;

    logic [63:0] mem [2**IDX_W][LINE_FLITS];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        bad_d     = bad_q;
        mshr_d    = mshr_q;
        idx_d     = idx_q;
        src_d     = src_q;
        dly_d     = dly_q;
        rx_beat_d = rx_beat_q;
        tx_beat_d = tx_beat_q;
        valid_d   = valid_q;
        data_d    = data_q;
        err_d     = err_q;
        rx_fire   = noc2_valid_in && ready_q;
        tx_fire   = valid_q && noc3_ready_out;
        req_done  = 1'b0;
        start_tx  = 1'b0;
        wr_en     = 1'b0;
        in_type   = noc2_data_in[21:14];

        case (state_q)
            RX_HDR: if (rx_fire) begin
                mshr_d    = noc2_data_in[13:6];
                cnt_d     = noc2_data_in[29:22];
                is_load_d = (in_type == LOAD_MEM);
                bad_d     = (in_type != LOAD_MEM) && (in_type != STORE_MEM);
                err_d     = err_q | bad_d;
                idx_d     = '0;
                src_d     = '0;
                rx_beat_d = '0;
                if (noc2_data_in[29:22] != 8'd0)
                    state_d = RX_ADDR;
                else if (!bad_d)
                    req_done = 1'b1;
            end
            RX_ADDR: if (rx_fire) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    // A lone flit is not treated as an address: the line stays at 0.
                    if (bad_q) state_d = RX_HDR;
                    else       req_done = 1'b1;
                end else begin
                    idx_d   = noc2_data_in[ADDR_LO +: IDX_W];
                    state_d = RX_SRC;
                end
            end
            RX_SRC: if (rx_fire) begin
                cnt_d = cnt_q - 8'd1;
                src_d = noc2_data_in[63:34];
                if (cnt_q == 8'd1) begin
                    if (bad_q) state_d = RX_HDR;
                    else       req_done = 1'b1;
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: if (rx_fire) begin
                cnt_d     = cnt_q - 8'd1;
                rx_beat_d = rx_beat_q + 8'd1;
                wr_en     = !bad_q && !is_load_q && (rx_beat_q < LINE_LEN);
                if (cnt_q == 8'd1) begin
                    if (bad_q) state_d = RX_HDR;
                    else       req_done = 1'b1;
                end
            end
            WAIT: begin
                if (dly_q == '0) start_tx = 1'b1;
                else             dly_d = dly_q - DLY_W'(1);
            end
            TX_HDR: if (tx_fire) begin
                if (is_load_q) begin
                    state_d   = TX_DATA;
                    tx_beat_d = '0;
                    data_d    = mem[idx_q][BEAT_W'(0)];
                end else begin
                    state_d = RX_HDR;
                    valid_d = 1'b0;
                end
            end
            TX_DATA: if (tx_fire) begin
                if (tx_beat_q == LAST_BEAT) begin
                    state_d = RX_HDR;
                    valid_d = 1'b0;
                end else begin
                    tx_beat_d = tx_beat_q + BEAT_W'(1);
                    data_d    = mem[idx_q][tx_beat_q + BEAT_W'(1)];
                end
            end
            default: state_d = RX_HDR;
        endcase

        // With no delay the header must be loaded on the same edge that takes the last flit.
        if (req_done) begin
            if (RESP_DELAY == 0) begin
                start_tx = 1'b1;
            end else begin
                state_d = WAIT;
                dly_d   = DLY_W'(RESP_DELAY - 1);
            end
        end

        if (start_tx) begin
            state_d = TX_HDR;
            valid_d = 1'b1;
            data_d  = {src_d, 4'h0, is_load_d ? LINE_LEN : 8'd0,
                       is_load_d ? LOAD_MEM_ACK : STORE_MEM_ACK, mshr_d, 6'h0};
        end

        ready_d = (state_d == RX_HDR) || (state_d == RX_ADDR) ||
                  (state_d == RX_SRC) || (state_d == RX_DATA);
        busy_d  = (state_d != RX_HDR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_HDR;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            bad_q     <= 1'b0;
            mshr_q    <= '0;
            idx_q     <= '0;
            src_q     <= '0;
            dly_q     <= '0;
            rx_beat_q <= '0;
            tx_beat_q <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            bad_q     <= bad_d;
            mshr_q    <= mshr_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
            dly_q     <= dly_d;
            rx_beat_q <= rx_beat_d;
            tx_beat_q <= tx_beat_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Store contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[idx_q][rx_beat_q[BEAT_W-1:0]] <= noc2_data_in;
    end

    assign noc2_ready_in  = ready_q;
    assign noc3_valid_out = valid_q;
    assign noc3_data_out  = data_q;
    assign busy           = busy_q;
    assign err_type       = err_q;
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: response flits are predicted into a queue
// as requests are driven and checked in order as the responder emits them.
module tb_l2_mem_responder;
    localparam int RESP_DELAY = 2;
    localparam logic [7:0] LD = 8'd19;
    localparam logic [7:0] ST = 8'd20;
    localparam logic [29:0] SRC_A = {14'h0003, 8'h01, 8'h02};
    localparam logic [29:0] SRC_B = {14'h0005, 8'h06, 8'h07};
    localparam logic [29:0] SRC_C = {14'h1ABC, 8'h3C, 8'hC3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        noc2_valid_in = 1'b0;
    logic [63:0] noc2_data_in = '0;
    logic        noc2_ready_in;
    logic        noc3_valid_out;
    logic [63:0] noc3_data_out;
    logic        noc3_ready_out = 1'b1;
    logic        busy;
    logic        err_type;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model [16][8];

    l2_mem_responder #(.IDX_W(4), .LINE_FLITS(8), .RESP_DELAY(RESP_DELAY), .ADDR_LO(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .noc2_valid_in(noc2_valid_in), .noc2_data_in(noc2_data_in), .noc2_ready_in(noc2_ready_in),
        .noc3_valid_out(noc3_valid_out), .noc3_data_out(noc3_data_out), .noc3_ready_out(noc3_ready_out),
        .busy(busy), .err_type(err_type)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; the handshake happens on the edge in between.
    task automatic send_flit(input logic [63:0] d, output int waits);
        noc2_valid_in = 1'b1;
        noc2_data_in  = d;
        waits = 0;
        while (!noc2_ready_in && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 200) begin
            n_cmp++; n_bad++;
            $error("FAIL send_timeout: observed ready 0 expected ready 1");
        end
        @(posedge clk); #1;
        noc2_valid_in = 1'b0;
    endtask

    task automatic send_req(input logic [7:0] typ, input int nbeats, input logic [39:0] addr,
                            input logic [29:0] src, input logic [7:0] mshr, input logic [63:0] base);
        int w;
        int idx;
        idx = int'(addr[9:6]);
        if (typ == ST) begin
            for (int k = 0; k < nbeats && k < 8; k++) model[idx][k] = base * 64'(k + 1);
            exp_q.push_back({src, 4'h0, 8'd0, 8'd25, mshr, 6'h0});
        end else begin
            exp_q.push_back({src, 4'h0, 8'd8, 8'd24, mshr, 6'h0});
            for (int k = 0; k < 8; k++) exp_q.push_back(model[idx][k]);
        end
        send_flit({14'h1A5, 8'hEE, 8'hDD, 4'hF, 8'(nbeats + 2), typ, mshr, 6'h2A}, w);
        send_flit({24'hA5A5A5, addr}, w);
        send_flit({src, 34'h2_1234_5678}, w);
        for (int k = 0; k < nbeats; k++) send_flit(base * 64'(k + 1), w);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || !noc2_ready_in || noc3_valid_out) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            n_cmp++; n_bad++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
        end
    endtask

    // Output monitor, sampling on the falling edge.
    initial begin
        bit stall_prev = 0;
        bit chk_rdy = 0;
        bit waiting_first = 0;
        int last_rx = 0;
        logic [63:0] stall_data = '0;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0; chk_rdy = 0; waiting_first = 0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(noc3_valid_out), 64'd1);
                    check("stall_hold", noc3_data_out, stall_data);
                end
                if (chk_rdy) begin
                    check("rdy_after_drain", 64'(noc2_ready_in), 64'd1);
                    chk_rdy = 0;
                end
                if (noc3_valid_out) begin
                    check("no_rx_during_tx", 64'(noc2_ready_in), 64'd0);
                    if (waiting_first) begin
                        check("resp_latency", 64'(cyc - last_rx), 64'(1 + RESP_DELAY));
                        waiting_first = 0;
                    end
                end
                if (noc3_valid_out && noc3_ready_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $error("FAIL unexpected_rsp: observed %h expected no flit", noc3_data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_flit", noc3_data_out, e);
                        $display("rsp flit %h expected %h", noc3_data_out, e);
                        if (exp_q.size() == 0) chk_rdy = 1;
                    end
                end
                stall_prev = noc3_valid_out && !noc3_ready_out;
                stall_data = noc3_data_out;
                if (noc2_valid_in && noc2_ready_in) begin
                    last_rx = cyc;
                    waiting_first = 1;
                end
            end
        end
    end

    initial begin
        int w;
        int wsum;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_ready", 64'(noc2_ready_in), 64'd0);
        check("rst_valid", 64'(noc3_valid_out), 64'd0);
        check("rst_data", noc3_data_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_type), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(noc2_ready_in), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);

        // Full-line store then load of the same line
        send_req(ST, 8, 40'h40, SRC_A, 8'd5, 64'h11);
        wait_drain();
        send_req(LD, 0, 40'h40, SRC_B, 8'd9, 64'h0);
        wait_drain();

        // Load with downstream stalled for 4 cycles on beat 3
        send_req(LD, 0, 40'h40, SRC_C, 8'd10, 64'h0);
        repeat (6) @(posedge clk); #1;
        noc3_ready_out = 1'b0;
        repeat (4) @(posedge clk); #1;
        noc3_ready_out = 1'b1;
        wait_drain();

        // Unsupported type, payload_len 4
        check("err_pre", 64'(err_type), 64'd0);
        send_flit({14'h0, 8'h0, 8'h0, 4'h0, 8'd4, 8'd7, 8'h12, 6'h0}, w);
        wsum = w;
        check("err_rise", 64'(err_type), 64'd1);
        for (int k = 0; k < 4; k++) begin
            send_flit(64'hF00D_0000 + 64'(k), w);
            wsum += w;
        end
        check("bad_full_rate", 64'(wsum), 64'd0);
        check("bad_busy", 64'(busy), 64'd0);
        repeat (8) @(posedge clk); #1;

        // Over-long store: beats 8-9 dropped
        send_req(ST, 10, 40'h80, SRC_A, 8'h33, 64'h0101_0101_0000_0000);
        wait_drain();
        send_req(LD, 0, 40'h80, SRC_B, 8'h34, 64'h0);
        wait_drain();

        // Short store leaves beats 3-7 untouched
        send_req(ST, 3, 40'h80, SRC_C, 8'h35, 64'hCAFE);
        wait_drain();
        send_req(LD, 0, 40'h80, SRC_A, 8'h36, 64'h0);
        wait_drain();
        check("err_sticky", 64'(err_type), 64'd1);

        // payload_len 0 and 1: source taken as 0
        exp_q.push_back({30'h0, 4'h0, 8'd0, 8'd25, 8'h40, 6'h0});
        send_flit({SRC_B, 4'h0, 8'd0, ST, 8'h40, 6'h0}, w);
        wait_drain();
        exp_q.push_back({30'h0, 4'h0, 8'd0, 8'd25, 8'h41, 6'h0});
        send_flit({SRC_B, 4'h0, 8'd1, ST, 8'h41, 6'h0}, w);
        send_flit({24'h0, 40'h40}, w);
        wait_drain();

        // Reset in the middle of a store's data phase
        send_req(ST, 8, 40'hC0, SRC_A, 8'h50, 64'h0BAD_0000_0000_0001);
        wait_drain();
        send_flit({14'h0, 8'h0, 8'h0, 4'h0, 8'd10, ST, 8'h51, 6'h0}, w);
        send_flit({24'h0, 40'hC0}, w);
        send_flit({SRC_B, 34'h0}, w);
        for (int k = 0; k < 3; k++) begin
            model[3][k] = 64'hDEAD_0000 + 64'(k);
            send_flit(64'hDEAD_0000 + 64'(k), w);
        end
        noc2_valid_in = 1'b1;
        noc2_data_in  = 64'hDEAD_0003;
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(noc2_ready_in), 64'd0);
        check("abort_valid", 64'(noc3_valid_out), 64'd0);
        check("abort_data", noc3_data_out, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_err", 64'(err_type), 64'd0);
        noc2_valid_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_ready_after", 64'(noc2_ready_in), 64'd1);
        send_req(LD, 0, 40'hC0, SRC_C, 8'h52, 64'h0);
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
